// File: rtl/axi_burst_mem.sv
// AXI4 slave bench memory with INCR/WRAP/FIXED bursts, ID echo and per-beat SLVERR.
// Define AXI_MEM_STALL_EN to add LFSR-driven ready/valid stalls.
module axi_burst_mem #(
    parameter int unsigned MEM_KB     = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4,
    parameter logic [15:0] STALL_SEED = 16'hACE1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [31:0]             awaddr_i,
    input  logic [7:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [1:0]              awburst_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [31:0]             araddr_i,
    input  logic [7:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [1:0]              arburst_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);
    localparam int unsigned NB       = DATA_WIDTH / 8;
    localparam int unsigned OffW     = $clog2(NB);
    localparam int unsigned Words    = MEM_KB * 1024 / NB;
    localparam int unsigned IdxW     = $clog2(Words);
    localparam logic [31:0] MemBytes = 32'(MEM_KB * 1024);
    localparam logic [2:0]  MaxSize  = 3'(OffW);
    localparam logic [1:0]  Okay     = 2'b00;
    localparam logic [1:0]  SlvErr   = 2'b10;

    typedef enum logic [1:0] {WIdle, WData, WResp} wstate_e;
    typedef enum logic {RIdle, RData} rstate_e;

    logic [DATA_WIDTH-1:0] mem_q [Words];
    logic                  stall;

`ifdef AXI_MEM_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) lfsr_q <= STALL_SEED;
        else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    // The seed only matters with stalls enabled; folding it in keeps the parameter referenced.
    assign stall = 1'b0 & (^STALL_SEED);
`endif

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == 2'b10) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (burst == 2'b11) || (size > MaxSize) || bad_wrap;
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step, nxt, wbytes, bnd;
        step   = 32'd1 << size;
        nxt    = (a & ~(step - 32'd1)) + step;
        wbytes = ({24'd0, len} + 32'd1) << size;
        bnd    = a & ~(wbytes - 32'd1);
        case (burst)
            2'b01:   return nxt;
            2'b10:   return (nxt == bnd + wbytes) ? bnd : nxt;
            default: return a;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [31:0] a,
                                                        input logic [2:0] size);
        logic [DATA_WIDTH-1:0] m;
        logic [31:0]           bytes, lo;
        bytes = 32'd1 << size;
        lo    = {{(32-OffW){1'b0}}, a[OffW-1:0]} & ~(bytes - 32'd1);
        for (int unsigned i = 0; i < NB; i++) begin
            m[8*i +: 8] = (i >= lo && i < lo + bytes) ? 8'hFF : 8'h00;
        end
        return m;
    endfunction

    // Write channel
    wstate_e             wstate_q;
    logic [ID_WIDTH-1:0] wid_q, bid_q;
    logic [31:0]         waddr_q;
    logic [7:0]          wlen_q, wcnt_q;
    logic [2:0]          wsize_q;
    logic [1:0]          wburst_q, bresp_q;
    logic                wberr_q, werr_q, awready_q, wready_q, bvalid_q;
    logic                w_hs, w_last_beat, w_beat_err, mem_we;

    assign awready_o   = awready_q && !stall;
    assign wready_o    = wready_q && !stall;
    assign bvalid_o    = bvalid_q;
    assign bresp_o     = bresp_q;
    assign bid_o       = bid_q;
    assign w_hs        = (wstate_q == WData) && wvalid_i && wready_o;
    assign w_last_beat = (wcnt_q == wlen_q);
    assign w_beat_err  = wberr_q || (waddr_q >= MemBytes) || (wlast_i != w_last_beat);
    assign mem_we      = !rst_i && w_hs && !wberr_q && (waddr_q < MemBytes);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wstate_q  <= WIdle;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= Okay;
            bid_q     <= '0;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            wberr_q   <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            unique case (wstate_q)
                WIdle: if (awvalid_i && awready_o) begin
                    wstate_q  <= WData;
                    awready_q <= 1'b0;
                    wready_q  <= 1'b1;
                    wid_q     <= awid_i;
                    waddr_q   <= awaddr_i;
                    wlen_q    <= awlen_i;
                    wsize_q   <= awsize_i;
                    wburst_q  <= awburst_i;
                    wberr_q   <= burst_err(awlen_i, awsize_i, awburst_i);
                    werr_q    <= 1'b0;
                    wcnt_q    <= '0;
                end
                WData: if (w_hs) begin
                    waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_q  <= wcnt_q + 8'd1;
                    werr_q  <= werr_q || w_beat_err;
                    if (w_last_beat) begin
                        wstate_q <= WResp;
                        wready_q <= 1'b0;
                        bvalid_q <= !stall;
                        bid_q    <= wid_q;
                        bresp_q  <= (werr_q || w_beat_err) ? SlvErr : Okay;
                    end
                end
                WResp: begin
                    if (!bvalid_q) begin
                        if (!stall) bvalid_q <= 1'b1;
                    end else if (bready_i) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= WIdle;
                    end
                end
                default: wstate_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wstrb_i[i]) mem_q[waddr_q[OffW +: IdxW]][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    // Read channel; the fetch reads mem_q before any same-cycle write lands.
    rstate_e               rstate_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [31:0]           raddr_q, rf_addr;
    logic [7:0]            rlen_q, rcnt_q;
    logic [2:0]            rsize_q, rf_size;
    logic [1:0]            rburst_q, rresp_q;
    logic                  rberr_q, arready_q, rvalid_q, rlast_q, rf_berr, rf_err;
    logic [DATA_WIDTH-1:0] rdata_q, rf_data;

    assign arready_o = arready_q && !stall;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;
    assign rlast_o   = rlast_q;
    assign rid_o     = rid_q;

    always_comb begin
        rf_addr = raddr_q;
        rf_size = rsize_q;
        rf_berr = rberr_q;
        if (rstate_q == RIdle) begin
            rf_addr = araddr_i;
            rf_size = arsize_i;
            rf_berr = burst_err(arlen_i, arsize_i, arburst_i);
        end
        rf_err  = rf_berr || (rf_addr >= MemBytes);
        rf_data = rf_err ? '0 : (mem_q[rf_addr[OffW +: IdxW]] & lane_mask(rf_addr, rf_size));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rstate_q  <= RIdle;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= Okay;
            rdata_q   <= '0;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rberr_q   <= 1'b0;
            rcnt_q    <= '0;
        end else begin
            unique case (rstate_q)
                RIdle: if (arvalid_i && arready_o) begin
                    rstate_q  <= RData;
                    arready_q <= 1'b0;
                    rid_q     <= arid_i;
                    rlen_q    <= arlen_i;
                    rsize_q   <= arsize_i;
                    rburst_q  <= arburst_i;
                    rberr_q   <= rf_berr;
                    rcnt_q    <= '0;
                    raddr_q   <= next_addr(araddr_i, arlen_i, arsize_i, arburst_i);
                    rdata_q   <= rf_data;
                    rresp_q   <= rf_err ? SlvErr : Okay;
                    rlast_q   <= (arlen_i == 8'd0);
                    rvalid_q  <= !stall;
                end
                RData: begin
                    if (!rvalid_q) begin
                        if (!stall) rvalid_q <= 1'b1;
                    end else if (rready_i) begin
                        if (rlast_q) begin
                            rstate_q  <= RIdle;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            rcnt_q   <= rcnt_q + 8'd1;
                            raddr_q  <= next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                            rdata_q  <= rf_data;
                            rresp_q  <= rf_err ? SlvErr : Okay;
                            rlast_q  <= (rcnt_q + 8'd1 == rlen_q);
                            rvalid_q <= !stall;
                        end
                    end
                end
                default: rstate_q <= RIdle;
            endcase
        end
    end
endmodule
